// File: rtl/vram_text_dump.sv
// vram_text_dump: scans the text VRAM row by row and streams each character as a byte, ending every row with CR/LF.
// Build macro VRAM_DUMP_FILTER_EN replaces non-printable bytes with '.'.
module vram_text_dump #(
  parameter int size = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        rd,
  output logic [12:0] addr_vram,
  input  logic [7:0]  data_vram,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int cols = 640 / size;
  localparam int rows = 480 / size;
  localparam logic [6:0] lastcol = 7'(cols - 1);
  localparam logic [6:0] lastrow = 7'(rows - 1);

  typedef enum logic [2:0] {IDLE, READ, LATCH, SEND, CR, LF, DONE} state_t;

  state_t     state;
  logic [6:0] row;
  logic [6:0] col;
  logic       handshake;

  assign handshake = tx_valid && tx_ready;

  function automatic logic [12:0] addr_of(input logic [6:0] r, input logic [6:0] c);
    return 13'(r) * 13'(cols) + 13'(c);
  endfunction

  // Empty cells (0x00) are shown as spaces so the terminal layout stays aligned.
  function automatic logic [7:0] map_char(input logic [7:0] b);
    logic [7:0] m;
    m = b;
    if (b == 8'h00)
      m = 8'h20;
`ifdef VRAM_DUMP_FILTER_EN
    else if (b < 8'h20 || b >= 8'h7F)
      m = 8'h2E;
`else
    else
      m = b;
`endif
    return m;
  endfunction

  // Outputs are registered and set on entry to the state that owns them.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      row       <= 7'd0;
      col       <= 7'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd        <= 1'b0;
      addr_vram <= 13'd0;
      tx_data   <= 8'h00;
      tx_valid  <= 1'b0;
    end else begin
      done <= 1'b0;
      rd   <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= READ;
            row       <= 7'd0;
            col       <= 7'd0;
            busy      <= 1'b1;
            rd        <= 1'b1;
            addr_vram <= 13'd0;
          end
        end
        READ: begin
          state <= LATCH;
        end
        LATCH: begin
          tx_data  <= map_char(data_vram);
          tx_valid <= 1'b1;
          state    <= SEND;
        end
        SEND: begin
          if (handshake) begin
            if (col == lastcol) begin
              tx_data <= 8'h0D;
              state   <= CR;
            end else begin
              col       <= col + 7'd1;
              tx_valid  <= 1'b0;
              rd        <= 1'b1;
              addr_vram <= addr_of(row, col + 7'd1);
              state     <= READ;
            end
          end
        end
        CR: begin
          if (handshake) begin
            tx_data <= 8'h0A;
            state   <= LF;
          end
        end
        LF: begin
          if (handshake) begin
            col      <= 7'd0;
            tx_valid <= 1'b0;
            if (row == lastrow) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              row       <= row + 7'd1;
              rd        <= 1'b1;
              addr_vram <= addr_of(row + 7'd1, 7'd0);
              state     <= READ;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_text_dump.sv
// tb_vram_text_dump: directed and randomized dumps of vram_text_dump checked against a page-level reference model.
module tb_vram_text_dump;

  localparam int SIZE = 16;
  localparam int COLS = 640 / SIZE;
  localparam int ROWS = 480 / SIZE;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b1;
  logic        tx_ready = 1'b1;
  logic        busy;
  logic        done;
  logic        rd;
  logic        tx_valid;
  logic [12:0] addr_vram;
  logic [7:0]  data_vram = 8'h00;
  logic [7:0]  tx_data;

  logic [7:0]  mem [0:8191];
  logic [7:0]  got [$];
  logic [7:0]  expq [$];

  int          n_asserts = 0;
  int          n_failures = 0;
  int          done_pulses = 0;
  bit          first_rd_seen = 1'b0;
  logic [12:0] first_rd_addr = 13'd0;
  bit          rand_ready = 1'b0;
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'h00;

  always #5 clk = ~clk;

  vram_text_dump #(.size(SIZE)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .busy     (busy),
    .done     (done),
    .rd       (rd),
    .addr_vram(addr_vram),
    .data_vram(data_vram),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  // Synchronous VRAM: data appears the cycle after rd.
  always @(posedge clk) begin
    if (rd) data_vram <= mem[addr_vram];
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      tx_ready = rand_ready ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_failures++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs settle #1 after posedge, so a negedge sample sees exactly what the next edge will use.
  always @(negedge clk) begin
    if (prev_stall) begin
      checkOutput("stall_valid", 32'(tx_valid), 32'd1);
      checkOutput("stall_data", 32'(tx_data), 32'(prev_data));
    end
    prev_stall = tx_valid && !tx_ready && !reset;
    prev_data  = tx_data;
    if (tx_valid && tx_ready && !reset) got.push_back(tx_data);
    if (done) done_pulses++;
    if (rd && !first_rd_seen) begin
      first_rd_seen = 1'b1;
      first_rd_addr = addr_vram;
    end
  end

  function automatic logic [7:0] expect_char(input logic [7:0] b);
    if (b == 8'h00) return 8'h20;
`ifdef VRAM_DUMP_FILTER_EN
    if (b < 8'h20 || b >= 8'h7F) return 8'h2E;
`endif
    return b;
  endfunction

  task automatic buildExpected();
    expq.delete();
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) expq.push_back(expect_char(mem[r * COLS + c]));
      expq.push_back(8'h0D);
      expq.push_back(8'h0A);
    end
  endtask

  task automatic compareStream(input string tag);
    int mism = 0;
    buildExpected();
    checkOutput({tag, "_len"}, 32'(got.size()), 32'(expq.size()));
    for (int i = 0; i < got.size() && i < expq.size(); i++) begin
      if (got[i] !== expq[i]) mism++;
    end
    checkOutput({tag, "_bytes_wrong"}, 32'(mism), 32'd0);
  endtask

  task automatic fillPattern();
    for (int a = 0; a < 8192; a++) mem[a] = 8'(8'h41 + (a % 26));
  endtask

  // One dump: start pulse, optional extra start at byte inject_at, optional reset at byte reset_at.
  task automatic applyStimulus(input int inject_at, input int reset_at);
    int cycles = 0;
    bit injected = 1'b0;
    got.delete();
    done_pulses   = 0;
    first_rd_seen = 1'b0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    checkOutput("busy_after_start", 32'(busy), 32'd1);
    while (done_pulses == 0 && cycles < 20000) begin
      start = 1'b0;
      if (inject_at >= 0 && !injected && got.size() >= inject_at) begin
        start    = 1'b1;
        injected = 1'b1;
      end
      if (reset_at >= 0 && got.size() >= reset_at) begin
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        checkOutput("reset_abort_outputs", 32'({busy, done, rd, tx_valid, addr_vram, tx_data}), 32'd0);
        return;
      end
      @(posedge clk); #1;
      cycles++;
    end
    start = 1'b0;
    checkOutput("dump_finished", 32'(cycles < 20000), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("done_pulses", 32'(done_pulses), 32'd1);
    checkOutput("idle_after_done", 32'({busy, tx_valid, rd}), 32'd0);
    checkOutput("first_rd_addr", 32'({first_rd_seen, first_rd_addr}), 32'({1'b1, 13'd0}));
  endtask

  initial begin
    fillPattern();

    $display("[TB] reset held with start high");
    @(posedge clk); #1;
    checkOutput("reset_cycle1", 32'({busy, done, rd, tx_valid, addr_vram}), 32'd0);
    @(posedge clk); #1;
    checkOutput("reset_cycle2", 32'({busy, done, rd, tx_valid, addr_vram}), 32'd0);
    reset = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    checkOutput("after_release", 32'({busy, done, rd, tx_valid, addr_vram, tx_data}), 32'd0);

    $display("[TB] full dump, tx_ready high");
    applyStimulus(-1, -1);
    checkOutput("total_bytes", 32'(got.size()), 32'd1260);
    checkOutput("byte0", 32'(got[0]), 32'h41);
    checkOutput("byte40_cr", 32'(got[40]), 32'h0D);
    checkOutput("byte41_lf", 32'(got[41]), 32'h0A);
    checkOutput("byte42_addr40", 32'(got[42]), 32'h4F);
    compareStream("ready_high");

    $display("[TB] full dump, tx_ready random 30%%");
    rand_ready = 1'b1;
    applyStimulus(-1, -1);
    rand_ready = 1'b0;
    compareStream("ready_random");

    $display("[TB] zero and control byte mapping");
    mem[0] = 8'h00;
    mem[1] = 8'h07;
    applyStimulus(-1, -1);
    checkOutput("zero_to_space", 32'(got[0]), 32'h20);
`ifdef VRAM_DUMP_FILTER_EN
    checkOutput("ctrl_filtered", 32'(got[1]), 32'h2E);
`else
    checkOutput("ctrl_passed", 32'(got[1]), 32'h07);
`endif
    compareStream("mapping");
    fillPattern();

    $display("[TB] second start at byte 10");
    applyStimulus(10, -1);
    checkOutput("restart_total", 32'(got.size()), 32'd1260);
    compareStream("restart_ignored");

    $display("[TB] reset at byte 100, then fresh dump");
    applyStimulus(-1, 100);
    @(posedge clk); #1;
    checkOutput("idle_after_reset", 32'({busy, tx_valid, rd}), 32'd0);
    applyStimulus(-1, -1);
    compareStream("after_reset");

    $display("[TB] random VRAM contents, random tx_ready");
    for (int a = 0; a < ROWS * COLS; a++) mem[a] = 8'($urandom_range(0, 255));
    rand_ready = 1'b1;
    applyStimulus(-1, -1);
    rand_ready = 1'b0;
    compareStream("random_page");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_failures);
    $finish;
  end

endmodule
